// File: rtl/frame_stream_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frame_stream_tx_pkg
//  Description : Shared FSM state encodings and sideband flag bit positions
//                for the pixel stream blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package frame_stream_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Sideband flags travel next to the pixel as {sof, eol, eof}
    localparam int c_FLAG_W   = 3;
    localparam int c_FLAG_SOF = 2;
    localparam int c_FLAG_EOL = 1;
    localparam int c_FLAG_EOF = 0;

    function automatic logic [c_FLAG_W-1:0] pack_flags(input logic sof,
                                                       input logic eol,
                                                       input logic eof);
        logic [c_FLAG_W-1:0] f;
        f             = '0;
        f[c_FLAG_SOF] = sof;
        f[c_FLAG_EOL] = eol;
        f[c_FLAG_EOF] = eof;
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_stream_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : frame_stream_tx_if
//  Description : Frame-buffer RAM read port plus valid/ready pixel stream.
//                master = the transmitter, slave = RAM + downstream sink.
//  Revision    : 1.0 - initial release
// ============================================================================
interface frame_stream_tx_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
);
    logic              o_mem_en;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] i_mem_data;
    logic              o_vld;
    logic              i_rdy;
    logic [DATA_W-1:0] o_data;
    logic              o_sof;
    logic              o_eol;
    logic              o_eof;

    modport master (
        output o_mem_en, o_mem_addr, o_vld, o_data, o_sof, o_eol, o_eof,
        input  i_mem_data, i_rdy
    );

    modport slave (
        input  o_mem_en, o_mem_addr, o_vld, o_data, o_sof, o_eol, o_eof,
        output i_mem_data, i_rdy
    );
endinterface
`default_nettype wire

// File: rtl/frame_stream_tx_fifo2.sv
`default_nettype none
// ============================================================================
//  Module      : frame_stream_tx_fifo2
//  Description : 2-entry register FIFO; head is presented from a register,
//                push and pop may coincide at any occupancy.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_stream_tx_fifo2 #(
    parameter int WIDTH = 11
) (
    input  wire logic             i_clk,
    input  wire logic             i_rst_n,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_push_data,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_head,
    output logic      [1:0]       o_count
);
    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic [1:0]       w_count_nxt;

    // Occupancy update for every push/pop combination
    always_comb begin
        w_count_nxt = r_count;
        case ({i_push, i_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage, pointers and count
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_count_nxt;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/frame_stream_tx.sv
`default_nettype none
// ============================================================================
//  Module      : frame_stream_tx
//  Description : Reads an IMG_W x IMG_H frame from a 1-cycle-latency RAM in
//                raster order and transmits it as a valid/ready pixel stream
//                with sof/eol/eof sideband flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_stream_tx
    import frame_stream_tx_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int ADDR_W = $clog2(IMG_W*IMG_H)
) (
    input  wire logic          i_clk,
    input  wire logic          i_rst_n,
    input  wire logic          i_start,
    output logic               o_busy,
    output logic               o_done,
    frame_stream_tx_if.master  bus
);
    localparam int c_X_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int c_Y_W   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int c_ENT_W = DATA_W + c_FLAG_W;
    localparam logic [c_X_W-1:0] c_X_LAST = c_X_W'(IMG_W - 1);
    localparam logic [c_Y_W-1:0] c_Y_LAST = c_Y_W'(IMG_H - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_X_W-1:0]    r_x;
    logic [c_Y_W-1:0]    r_y;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_inflight;
    logic [c_FLAG_W-1:0] r_infl_flags;

    logic                w_issue;
    logic                w_pop;
    logic                w_done;
    logic                w_at_eol;
    logic                w_at_eof;
    logic [c_FLAG_W-1:0] w_flags;
    logic [2:0]          w_occ;
    logic [1:0]          w_count;
    logic [c_ENT_W-1:0]  w_head;

    // Flags belong to the address being issued this cycle
    assign w_at_eol = (r_x == c_X_LAST);
    assign w_at_eof = w_at_eol && (r_y == c_Y_LAST);
    assign w_flags  = pack_flags((r_x == '0) && (r_y == '0), w_at_eol, w_at_eof);

    // Credit rule: buffered + in-flight pixels, minus the one leaving now,
    // must stay below the FIFO depth so a returning read always has a slot.
    assign w_pop   = bus.o_vld && bus.i_rdy;
    assign w_occ   = 3'(w_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_issue = (r_state == ST_RUN) && (w_occ < 3'd2);

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state; done fires once the last pixel has left and nothing is pending
    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_issue && w_at_eof) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((w_count == 2'd0) && !r_inflight) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Raster address counters advance only on an issued read and wrap to 0 after the frame
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
        end else if (w_issue) begin
            if (w_at_eol) begin
                r_x <= '0;
                r_y <= w_at_eof ? '0 : r_y + c_Y_W'(1);
            end else begin
                r_x <= r_x + c_X_W'(1);
            end
            r_addr <= w_at_eof ? '0 : r_addr + ADDR_W'(1);
        end
    end

    // One-cycle read pipeline: flags wait alongside the RAM access
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_inflight   <= 1'b0;
            r_infl_flags <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_infl_flags <= w_flags;
            end
        end
    end

    frame_stream_tx_fifo2 #(
        .WIDTH (c_ENT_W)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (r_inflight),
        .i_push_data ({bus.i_mem_data, r_infl_flags}),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    assign bus.o_mem_en   = w_issue;
    assign bus.o_mem_addr = r_addr;
    assign bus.o_vld      = (w_count != 2'd0);
    assign bus.o_data     = w_head[c_ENT_W-1:c_FLAG_W];
    assign bus.o_sof      = w_head[c_FLAG_SOF];
    assign bus.o_eol      = w_head[c_FLAG_EOL];
    assign bus.o_eof      = w_head[c_FLAG_EOF];
    assign o_busy         = (r_state != ST_IDLE);
    assign o_done         = w_done;

endmodule
`default_nettype wire
